sr_sipo_rx: RTL and testbench

SR_SIPO_RX -- requirements
Module: sr_sipo_rx

---
 rtl/sr_pkg.sv | 25 ++
 rtl/sr_rx_outbuf.sv | 47 ++++
 rtl/sr_sipo_rx.sv | 128 ++++++++++++
 tb/tb_sr_sipo_rx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and constants for the serial-in/parallel-out receiver.
// SR_SIPO_PARITY_EN adds the PARITY state to the receiver FSM.
package sr_pkg;

  localparam int SR_WIDTH_DEF = 4;

`ifdef SR_SIPO_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } sr_rx_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } sr_rx_state_t;
`endif

  // Even parity over data plus parity bit; returns 1 when the check fails.
  function automatic logic even_parity_err(input logic [15:0] data, input logic pbit);
    return (^data) ^ pbit;
  endfunction

endpackage

// File: rtl/sr_rx_outbuf.sv
// Output holding register: valid/ready handshake, drop-on-full and sticky overrun.
module sr_rx_outbuf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_perr,
  input  logic             pout_ready,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  output logic             overrun,
  output logic             parity_err
);

  logic accept_s;
  logic drop_s;

  // A completed word is taken when the buffer is empty or being drained this cycle.
  always_comb begin
    accept_s = wr_en & (~pout_valid | pout_ready);
    drop_s   = wr_en & pout_valid & ~pout_ready;
  end

  // Holding register and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pout       <= '0;
      pout_valid <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (accept_s) begin
        pout       <= wr_data;
        pout_valid <= 1'b1;
        parity_err <= wr_perr;
      end else if (pout_valid && pout_ready) begin
        pout_valid <= 1'b0;
      end
      if (drop_s) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_sipo_rx.sv
// Serial-in/parallel-out receiver, MSB first, framed by sin_first.
// Define SR_SIPO_PARITY_EN to expect a trailing even-parity bit per word.
module sr_sipo_rx
  import sr_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_first,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

  sr_rx_state_t     state_r, state_n;
  logic [CW-1:0]    cnt_r, cnt_n;
  logic [WIDTH-1:0] shreg_r, shreg_n;
  logic             busy_r;
  logic             done_s;
  logic [WIDTH-1:0] done_word_s;
  logic             done_perr_s;

  // Next-state, counter and shift-register logic.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    shreg_n     = shreg_r;
    done_s      = 1'b0;
    done_word_s = shreg_r;
    done_perr_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sin_valid && sin_first) begin
          shreg_n = {{(WIDTH-1){1'b0}}, sin};
          cnt_n   = CW'(1);
          state_n = ST_SHIFT;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sin_valid && sin_first) begin
          shreg_n = {{(WIDTH-1){1'b0}}, sin};
          cnt_n   = CW'(1);
          state_n = ST_SHIFT;
        end else if (sin_valid) begin
          shreg_n = {shreg_r[WIDTH-2:0], sin};
          if (cnt_r == CW'(WIDTH - 1)) begin
`ifdef SR_SIPO_PARITY_EN
            cnt_n   = CW'(WIDTH);
            state_n = ST_PARITY;
`else
            done_s      = 1'b1;
            done_word_s = shreg_n;
            cnt_n       = '0;
            state_n     = ST_IDLE;
`endif
          end else begin
            cnt_n = cnt_r + CW'(1);
          end
        end else begin
          state_n = ST_SHIFT;
        end
      end
`ifdef SR_SIPO_PARITY_EN
      ST_PARITY: begin
        if (sin_valid && sin_first) begin
          shreg_n = {{(WIDTH-1){1'b0}}, sin};
          cnt_n   = CW'(1);
          state_n = ST_SHIFT;
        end else if (sin_valid) begin
          done_s      = 1'b1;
          done_word_s = shreg_r;
          done_perr_s = even_parity_err(16'(shreg_r), sin);
          cnt_n       = '0;
          state_n     = ST_IDLE;
        end else begin
          state_n = ST_PARITY;
        end
      end
`endif
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        shreg_n = '0;
      end
    endcase
  end

  // State register; busy is registered from the next state so it tracks state_r exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      shreg_r <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      shreg_r <= shreg_n;
      busy_r  <= (state_n != ST_IDLE);
    end
  end

  assign busy = busy_r;

  sr_rx_outbuf #(.WIDTH(WIDTH)) u_outbuf (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (done_s),
    .wr_data    (done_word_s),
    .wr_perr    (done_perr_s),
    .pout_ready (pout_ready),
    .pout       (pout),
    .pout_valid (pout_valid),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

endmodule

// File: tb/tb_sr_sipo_rx.sv
// Directed bench for sr_sipo_rx (WIDTH=4); parity checks run when SR_SIPO_PARITY_EN is defined.
module tb_sr_sipo_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       sin_valid;
  logic       sin_first;
  logic [3:0] pout;
  logic       pout_valid;
  logic       pout_ready;
  logic       busy;
  logic       overrun;
  logic       parity_err;

  int n_tests = 0;
  int n_fail  = 0;

  sr_sipo_rx #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_first  (sin_first),
    .pout       (pout),
    .pout_valid (pout_valid),
    .pout_ready (pout_ready),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       sin;
    logic       v;
    logic       f;
    logic       rdy;
    logic [3:0] e_pout;
    logic       e_pv;
    logic       e_busy;
    logic       e_ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic step(input logic r, input logic s, input logic v, input logic f, input logic rdy);
    rst        = r;
    sin        = s;
    sin_valid  = v;
    sin_first  = f;
    pout_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packs {pout, pout_valid, busy, overrun, parity_err} for one compare.
  function automatic logic [31:0] obs();
    return {24'd0, pout, pout_valid, busy, overrun, parity_err};
  endfunction

  function automatic logic [31:0] expv(input logic [3:0] p, input logic pv, input logic b,
                                       input logic o, input logic pe);
    return {24'd0, p, pv, b, o, pe};
  endfunction

  task automatic add(input logic r, input logic s, input logic v, input logic f, input logic rdy,
                     input logic [3:0] ep, input logic epv, input logic eb, input logic eo);
    vecs.push_back('{r, s, v, f, rdy, ep, epv, eb, eo});
  endtask

  initial begin
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sin_first = 1'b0; pout_ready = 1'b0;

`ifndef SR_SIPO_PARITY_EN
    //  rst sin v  f  rdy  pout  pv busy ovr
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); // reset
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0); // word B
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0); // consumed
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hB, 1'b0, 1'b1, 1'b0); // 1,0 then restart
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hB, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hB, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hB, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hB, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h6, 1'b0, 1'b1, 1'b0); // B, ready low
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h6, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h6, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hB, 1'b1, 1'b1, 1'b0); // 6 dropped
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b1); // drain, overrun sticky
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b1); // no sin_first: ignored
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1); // 2 bits then reset
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0); // word 9
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h9, 1'b1, 1'b1, 1'b0); // word 6 while 9 held
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 1'b1, 1'b0, 1'b0); // drain+complete same cycle
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].sin, vecs[i].v, vecs[i].f, vecs[i].rdy);
      chk($sformatf("vec%0d", i), obs(),
          expv(vecs[i].e_pout, vecs[i].e_pv, vecs[i].e_busy, vecs[i].e_ovr, 1'b0));
    end

    // Gapped word B: three idle cycles between bits, busy held throughout.
    begin
      logic [3:0] bits;
      bits = 4'b1011;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int b = 3; b >= 0; b--) begin
        step(1'b0, bits[b], 1'b1, (b == 3), 1'b1);
        chk($sformatf("gap_busy_bit%0d", 3 - b), {31'd0, busy}, {31'd0, (b != 0)});
        if (b != 0) begin
          for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            chk("gap_idle", {30'd0, busy, pout_valid}, {30'd0, 1'b1, 1'b0});
          end
        end
      end
      chk("gap_word", obs(), expv(4'hB, 1'b1, 1'b0, 1'b0, 1'b0));
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("gap_clear", {31'd0, pout_valid}, 32'd0);
    end
`else
    // Parity build: 4'hB followed by parity 1 (good), then parity 0 (bad).
    begin
      logic [4:0] frame;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("par_reset", obs(), expv(4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int w = 0; w < 2; w++) begin
        frame = (w == 0) ? 5'b10111 : 5'b10110;
        for (int b = 4; b >= 1; b--) begin
          step(1'b0, frame[b], 1'b1, (b == 4), 1'b1);
          chk($sformatf("par%0d_busy%0d", w, 4 - b), {31'd0, busy}, 32'd1);
          chk($sformatf("par%0d_pv%0d", w, 4 - b), {31'd0, pout_valid}, 32'd0);
        end
        step(1'b0, frame[0], 1'b1, 1'b0, 1'b1);
        chk($sformatf("par%0d_word", w), obs(), expv(4'hB, 1'b1, 1'b0, 1'b0, (w == 1)));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk($sformatf("par%0d_clear", w), {31'd0, pout_valid}, 32'd0);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
